irq_sched: RTL

Prioritising interrupt scheduler for the 8-bit CPU core. It edge-detects up to N_SRC interrupt sources (software trap, protection fault, timer1, timer2, key, spare) into a pending register. It selects the highest-priority unmasked pending source and presents it to the CPU core through a request/acknowledge handshake. It then blocks further requests until the core signals interrupt return. Its four 8-bit registers sit in the memory-mapped I/O window alongside the timer and LED/switch registers; the CPU reads them with the same one-cycle read latency as RAM.

---
 rtl/irq_pkg.sv | 30 +++
 rtl/irq_sched_prio_enc.sv | 20 ++
 rtl/irq_sched.sv | 123 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt scheduler: register map, FSM states,
// source numbering and the control register layout.
package irq_pkg;

  localparam int unsigned REG_AW = 2;
  localparam int unsigned REG_DW = 8;

  localparam logic [REG_AW-1:0] IRQ_PEND = 2'd0;
  localparam logic [REG_AW-1:0] IRQ_MASK = 2'd1;
  localparam logic [REG_AW-1:0] IRQ_STAT = 2'd2;
  localparam logic [REG_AW-1:0] IRQ_CTRL = 2'd3;

  localparam int unsigned SRC_SW    = 0;
  localparam int unsigned SRC_FAULT = 1;
  localparam int unsigned SRC_T1    = 2;
  localparam int unsigned SRC_T2    = 3;
  localparam int unsigned SRC_KEY   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } irq_state_t;

  typedef struct packed {
    logic hold;
    logic gie;
  } irq_ctrl_t;

endpackage

// File: rtl/irq_sched_prio_enc.sv
// Lowest-index-wins priority encoder; index 0 is the highest priority.
module prio_enc #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid_c,
  output logic [W-1:0] idx_c
);

  // Scan from the top so the lowest set index is the last assignment.
  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx_c = W'(i);
    end
  end

endmodule

// File: rtl/irq_sched.sv
// Prioritising interrupt scheduler: edge-detected pending sources, one
// committed request to the core at a time, blocked until interrupt return.
module irq_sched
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned VEC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src,
  input  logic              user_mode,
  output logic              irq_req,
  output logic [VEC_W-1:0]  irq_vec,
  input  logic              irq_ack,
  input  logic              irq_done,
  input  logic              reg_we,
  input  logic [REG_AW-1:0] reg_addr,
  input  logic [REG_DW-1:0] reg_wdata,
  output logic [REG_DW-1:0] reg_rdata
);

  irq_state_t        state;
  irq_ctrl_t         ctrl;
  logic [N_SRC-1:0]  src_q;
  logic [N_SRC-1:0]  pend;
  logic [N_SRC-1:0]  mask;
  logic [N_SRC-1:0]  rise_c;
  logic [N_SRC-1:0]  pend_clr_c;
  logic              enc_valid_c;
  logic [VEC_W-1:0]  enc_idx_c;
  logic              wr_pend_c;
  logic              wr_mask_c;
  logic              wr_ctrl_c;
  logic              ack_c;
  logic              gie_drop_c;
  logic [REG_DW-1:0] rd_c;

  assign rise_c     = src & ~src_q;
  assign wr_pend_c  = reg_we && (reg_addr == IRQ_PEND);
  assign wr_mask_c  = reg_we && (reg_addr == IRQ_MASK);
  assign wr_ctrl_c  = reg_we && (reg_addr == IRQ_CTRL);
  assign ack_c      = (state == REQ) && irq_ack;
  assign gie_drop_c = wr_ctrl_c && !reg_wdata[0];

  prio_enc #(
    .N (N_SRC),
    .W (VEC_W)
  ) u_prio_enc (
    .req     (pend & mask),
    .valid_c (enc_valid_c),
    .idx_c   (enc_idx_c)
  );

  // Software W1C and ack both clear; a same-cycle rise still sets the bit.
  always_comb begin
    pend_clr_c = wr_pend_c ? reg_wdata[N_SRC-1:0] : '0;
    if (ack_c && !ctrl.hold) pend_clr_c[irq_vec] = 1'b1;
  end

  always_comb begin
    rd_c = '0;
    case (reg_addr)
      IRQ_PEND: rd_c = REG_DW'(pend);
      IRQ_MASK: rd_c = REG_DW'(mask);
      IRQ_STAT: rd_c = {state, 6'(irq_vec)};
      IRQ_CTRL: rd_c = {6'd0, ctrl};
      default:  rd_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pend      <= '0;
      mask      <= '0;
      ctrl      <= '0;
      reg_rdata <= '0;
    end else begin
      src_q     <= src;
      pend      <= (pend & ~pend_clr_c) | rise_c;
      reg_rdata <= rd_c;
      if (wr_mask_c) mask <= reg_wdata[N_SRC-1:0];
      if (wr_ctrl_c) ctrl <= irq_ctrl_t'(reg_wdata[1:0]);
    end
  end

  // Request FSM; the vector is latched on entry to REQ and never re-evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl.gie && user_mode && enc_valid_c) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_vec <= enc_idx_c;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (gie_drop_c) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
